// File: rtl/aes_prng_sched_if.sv
// Host, AES core and PRNG signals of the AES/PRNG sequencer.
// master drives the sequencer inputs; slave is the sequencer side.
interface aes_prng_sched_if #(
  parameter int CNT_W = 16
) ();
  logic [79:0]      seed_in;
  logic             seed_valid;
  logic             seed_ready;
  logic             force_reseed;
  logic             in_valid;
  logic             in_ready;
  logic             core_valid_in;
  logic             core_ready;
  logic             core_cipher_valid;
  logic [79:0]      prng_seed;
  logic             prng_start_reseed;
  logic             prng_busy;
  logic             prng_out_valid;
  logic             prng_out_ready;
  logic [CNT_W-1:0] enc_count;
  logic             rnd_starved;

  modport master (
    output seed_in, seed_valid, force_reseed,
    output in_valid, core_ready, core_cipher_valid,
    output prng_busy, prng_out_valid,
    input  seed_ready, in_ready, core_valid_in,
    input  prng_seed, prng_start_reseed,
    input  prng_out_ready, enc_count, rnd_starved
  );

  modport slave (
    input  seed_in, seed_valid, force_reseed,
    input  in_valid, core_ready, core_cipher_valid,
    input  prng_busy, prng_out_valid,
    output seed_ready, in_ready, core_valid_in,
    output prng_seed, prng_start_reseed,
    output prng_out_ready, enc_count, rnd_starved
  );
endinterface

// File: rtl/aes_prng_sched.sv
// Sequencer for the masked AES core and its PRNG (seed, warm-up, run).
// Define AUTO_RESEED_EN to reseed after every RESEED_PERIOD encryptions.
module aes_prng_sched #(
  parameter int RESEED_PERIOD = 1024,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              nrst,
  aes_prng_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_SEED,
    S_KICK,
    S_WARM,
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [79:0]      seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             starve_q;

  logic             seed_rdy;
  logic             in_rdy;
  logic             core_vin;
  logic             kick;
  logic             rnd_rdy;
  logic             due;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat = cnt_inc[CNT_W] ? cnt_q
                                  : cnt_inc[CNT_W-1:0];

`ifdef AUTO_RESEED_EN
  assign due = (cnt_inc == (CNT_W+1)'(RESEED_PERIOD));
`else
  assign due = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    seed_rdy = 1'b0;
    in_rdy   = 1'b0;
    core_vin = 1'b0;
    kick     = 1'b0;
    rnd_rdy  = 1'b0;

    if (bus.force_reseed &&
        state_q != S_SEED && state_q != S_KICK)
      pend_d = 1'b1;

    unique case (state_q)
      S_SEED: begin
        seed_rdy = 1'b1;
        if (bus.seed_valid) begin
          seed_d  = bus.seed_in;
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        kick    = 1'b1;
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = S_WARM;
      end
      S_WARM: begin
        if (!bus.prng_busy && bus.prng_out_valid)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        in_rdy   = bus.core_ready & bus.prng_out_valid
                 & ~pend_q;
        core_vin = bus.in_valid & in_rdy;
        if (pend_q)
          state_d = S_SEED;
        else if (core_vin)
          state_d = S_RUN;
      end
      S_RUN: begin
        rnd_rdy = 1'b1;
        if (bus.core_cipher_valid) begin
          cnt_d = cnt_sat;
          // a reseed request landing on completion counts now
          if (due || pend_q || bus.force_reseed)
            state_d = S_SEED;
          else
            state_d = S_IDLE;
        end
      end
      default: state_d = S_SEED;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_SEED;
      seed_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      if (state_q == S_RUN && !bus.prng_out_valid)
        starve_q <= 1'b1;
    end
  end

  assign bus.seed_ready        = seed_rdy;
  assign bus.in_ready          = in_rdy;
  assign bus.core_valid_in     = core_vin;
  assign bus.prng_seed         = seed_q;
  assign bus.prng_start_reseed = kick;
  assign bus.prng_out_ready    = rnd_rdy;
  assign bus.enc_count         = cnt_q;
  assign bus.rnd_starved       = starve_q;

endmodule

// File: tb/tb_aes_prng_sched.sv
// Directed bench for aes_prng_sched with a hand-driven core/PRNG.
// Build with or without AUTO_RESEED_EN.
module tb_aes_prng_sched;

`ifdef AUTO_RESEED_EN
  localparam int RP = 3;
`else
  localparam int RP = 15;
`endif
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic nrst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  aes_prng_sched_if #(.CNT_W(CW)) bus ();

  aes_prng_sched #(
    .RESEED_PERIOD(RP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  task automatic check(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [79:0] v);
    bus.seed_in    = v;
    bus.seed_valid = 1'b1;
    #1;
    check("seed_ready", bus.seed_ready, 1);
    check("idle_in_rdy_seed", bus.in_ready, 0);
    tick();
    bus.seed_valid     = 1'b0;
    bus.seed_in        = '0;
    bus.prng_busy      = 1'b1;
    bus.prng_out_valid = 1'b0;
    #1;
    check("kick_pulse", bus.prng_start_reseed, 1);
    check("prng_seed", bus.prng_seed, v);
    tick();
    check("kick_end", bus.prng_start_reseed, 0);
    check("cnt_clr", bus.enc_count, 0);
    exp_cnt = 0;
    tick();
    check("warm_busy", bus.in_ready, 0);
    bus.prng_busy = 1'b0;
    tick();
    check("warm_novalid", bus.in_ready, 0);
    bus.prng_out_valid = 1'b1;
    #1;
    check("warm_exit_cyc", bus.in_ready, 0);
    tick();
    check("in_ready_first", bus.in_ready, 1);
    check("seed_held", bus.prng_seed, v);
  endtask

  task automatic run_enc(input int lat,
                         input int force_at,
                         input int drop_at);
    int w;
    int hi;
    w  = 0;
    hi = 0;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("admit", bus.in_ready, 1);
    check("core_vin", bus.core_valid_in, 1);
    for (int i = 1; i <= lat; i++) begin
      tick();
      bus.in_valid          = (i == 1);
      bus.force_reseed      = (i == force_at);
      bus.prng_out_valid    = (i != drop_at);
      bus.core_cipher_valid = (i == lat);
      #1;
      if (bus.prng_out_ready) hi++;
      if (i == 1)
        check("core_vin_run", bus.core_valid_in, 0);
    end
    tick();
    bus.in_valid          = 1'b0;
    bus.force_reseed      = 1'b0;
    bus.prng_out_valid    = 1'b1;
    bus.core_cipher_valid = 1'b0;
    #1;
    if (exp_cnt < CMAX) exp_cnt++;
    check("rdy_len", hi, lat);
    check("rdy_drop", bus.prng_out_ready, 0);
    check("enc_count", bus.enc_count, exp_cnt);
  endtask

  initial begin
    nrst                  = 1'b0;
    bus.seed_in           = '0;
    bus.seed_valid        = 1'b0;
    bus.force_reseed      = 1'b0;
    bus.in_valid          = 1'b0;
    bus.core_ready        = 1'b1;
    bus.core_cipher_valid = 1'b0;
    bus.prng_busy         = 1'b0;
    bus.prng_out_valid    = 1'b0;
    #2;
    check("rst_seed_rdy", bus.seed_ready, 1);
    check("rst_seed", bus.prng_seed, 0);
    check("rst_cnt", bus.enc_count, 0);
    check("rst_starve", bus.rnd_starved, 0);
    check("rst_in_rdy", bus.in_ready, 0);
    check("rst_kick", bus.prng_start_reseed, 0);
    check("rst_out_rdy", bus.prng_out_ready, 0);
    #10;
    nrst = 1'b1;
    tick();

    do_seed(80'h0123_4567_89AB_CDEF_0F1E);
    run_enc(10, 0, 0);
    check("ret_in_rdy", bus.in_ready, 1);
    check("cnt_one", bus.enc_count, 1);

`ifdef AUTO_RESEED_EN
    run_enc(2, 0, 0);
    check("p2_in_rdy", bus.in_ready, 1);
    check("p2_no_seed", bus.seed_ready, 0);
    run_enc(2, 0, 0);
    check("auto_seed_rdy", bus.seed_ready, 1);
    check("auto_in_rdy", bus.in_ready, 0);
    do_seed(80'hA5A5_0000_1111_2222_3333);
`else
    while (exp_cnt < 5) run_enc(2, 0, 0);
`endif

    run_enc(4, 2, 0);
    check("frc_seed_rdy", bus.seed_ready, 1);
    check("frc_in_rdy", bus.in_ready, 0);
    do_seed(80'h1111_2222_3333_4444_5555);

    bus.force_reseed = 1'b1;
    #1;
    check("idle_pre_frc", bus.in_ready, 1);
    tick();
    bus.force_reseed = 1'b0;
    bus.in_valid     = 1'b1;
    #1;
    check("idle_frc_blk", bus.in_ready, 0);
    check("idle_frc_vin", bus.core_valid_in, 0);
    tick();
    bus.in_valid = 1'b0;
    check("idle_frc_seed", bus.seed_ready, 1);
    do_seed(80'hFEDC_BA98_7654_3210_ABCD);

`ifndef AUTO_RESEED_EN
    repeat (CMAX + 1) run_enc(1, 0, 0);
    check("cnt_sat", bus.enc_count, CMAX);
    check("sat_in_rdy", bus.in_ready, 1);
`endif

    run_enc(5, 0, 3);
    check("starve_set", bus.rnd_starved, 1);
    run_enc(2, 0, 0);
    check("starve_hold", bus.rnd_starved, 1);

    bus.in_valid = 1'b1;
    #1;
    check("rst_admit", bus.core_valid_in, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("rst_run", bus.prng_out_ready, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_seed_rdy", bus.seed_ready, 1);
    check("arst_out_rdy", bus.prng_out_ready, 0);
    check("arst_in_rdy", bus.in_ready, 0);
    check("arst_kick", bus.prng_start_reseed, 0);
    check("arst_seed", bus.prng_seed, 0);
    check("arst_cnt", bus.enc_count, 0);
    check("arst_starve", bus.rnd_starved, 0);
    #3;
    nrst = 1'b1;
    tick();
    check("post_rst_seed", bus.seed_ready, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
